param_fifo: RTL and testbench

//  Parametrised synchronous FIFO buffering accelerometer sample bytes/words between the

---
 rtl/param_fifo.sv | 115 +++++++++++
 tb/tb_param_fifo.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/param_fifo.sv
// param_fifo: parametrised synchronous FIFO that buffers accelerometer samples
// between the sensor capture path and the UART/readout path.
// Adds an occupancy count, programmable almost-full/almost-empty flags, and
// per-port pulse (rising-edge) or level request qualification.
// Optional macro FIFO_ERR_FLAGS_EN adds sticky overflow/underflow outputs.
module param_fifo #(
  parameter int DWIDTH   = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = 12,
  parameter int AE_LEVEL = 2,
  localparam int CW      = $clog2(DEPTH + 1)
) (
  input  logic              sys_clock,
  input  logic              reset,
  input  logic              pulse_mode,
  input  logic              write_en,
  input  logic [DWIDTH-1:0] di,
  input  logic              read_en,
  output logic [DWIDTH-1:0] d_out,
  output logic              isEmpty,
  output logic              isFull,
  output logic              isAlmostEmpty,
  output logic              isAlmostFull,
  output logic [CW-1:0]     count
`ifdef FIFO_ERR_FLAGS_EN
  ,
  output logic              overflow,
  output logic              underflow
`endif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  logic [DWIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr_next;
  logic [PW-1:0]     rd_ptr_next;
  logic              write_en_q;
  logic              read_en_q;
  logic              wr_req;
  logic              rd_req;
  logic              wr_acc;
  logic              rd_acc;

  // Request qualification and acceptance; a full FIFO still takes a write
  // when a read frees a slot on the same edge.
  always_comb begin
    wr_req      = pulse_mode ? (write_en & ~write_en_q) : write_en;
    rd_req      = pulse_mode ? (read_en & ~read_en_q) : read_en;
    rd_acc      = rd_req & ~isEmpty;
    wr_acc      = wr_req & (~isFull | rd_acc);
    wr_ptr_next = (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PW'(1);
    rd_ptr_next = (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PW'(1);
  end

  // Flags follow the registered count directly, so they change on the same edge.
  assign isEmpty       = (count == '0);
  assign isFull        = (int'(count) == DEPTH);
  assign isAlmostEmpty = (int'(count) <= AE_LEVEL);
  assign isAlmostFull  = (int'(count) >= AF_LEVEL);

  // Storage array: written on accepted writes only, never cleared by reset.
  always_ff @(posedge sys_clock) begin
    if (wr_acc && !reset) begin
      mem[wr_ptr] <= di;
    end
  end

  // Pointers, occupancy, registered read data and request history.
  always_ff @(posedge sys_clock) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      d_out      <= '0;
      write_en_q <= 1'b0;
      read_en_q  <= 1'b0;
    end else begin
      write_en_q <= write_en;
      read_en_q  <= read_en;
      if (wr_acc) begin
        wr_ptr <= wr_ptr_next;
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr_next;
        d_out  <= mem[rd_ptr];
      end
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef FIFO_ERR_FLAGS_EN
  // Sticky error flags recording any dropped write or read since reset.
  always_ff @(posedge sys_clock) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_req && !wr_acc) begin
        overflow <= 1'b1;
      end
      if (rd_req && !rd_acc) begin
        underflow <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_param_fifo.sv
// tb_param_fifo: directed bench for param_fifo with a scoreboard queue.
// Main instance uses default parameters; a second DEPTH=5 instance exercises wrap.
module tb_param_fifo;

  logic       sys_clock = 1'b0;
  logic       reset = 1'b1;
  logic       pulse_mode = 1'b1;
  logic       write_en = 1'b0;
  logic       read_en = 1'b0;
  logic [7:0] di = 8'h00;
  logic [7:0] d_out;
  logic       isEmpty, isFull, isAlmostEmpty, isAlmostFull;
  logic [4:0] count;

  logic       s_reset = 1'b1;
  logic       s_we = 1'b0;
  logic       s_re = 1'b0;
  logic [7:0] s_di = 8'h00;
  logic [7:0] s_dout;
  logic       s_empty, s_full, s_ae, s_af;
  logic [2:0] s_count;

`ifdef FIFO_ERR_FLAGS_EN
  logic overflow, underflow, s_ovf, s_unf;
`endif

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [7:0] dout;
    int         cnt;
    bit         ovf;
    bit         unf;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] m_q[$];
  logic [7:0] m_dout = 8'h00;
  bit         m_we = 1'b0;
  bit         m_re = 1'b0;
  bit         m_ovf = 1'b0;
  bit         m_unf = 1'b0;

  param_fifo dut (
    .sys_clock(sys_clock), .reset(reset), .pulse_mode(pulse_mode),
    .write_en(write_en), .di(di), .read_en(read_en), .d_out(d_out),
    .isEmpty(isEmpty), .isFull(isFull), .isAlmostEmpty(isAlmostEmpty),
    .isAlmostFull(isAlmostFull), .count(count)
`ifdef FIFO_ERR_FLAGS_EN
    , .overflow(overflow), .underflow(underflow)
`endif
  );

  param_fifo #(.DEPTH(5), .AF_LEVEL(4), .AE_LEVEL(1)) small_dut (
    .sys_clock(sys_clock), .reset(s_reset), .pulse_mode(1'b0),
    .write_en(s_we), .di(s_di), .read_en(s_re), .d_out(s_dout),
    .isEmpty(s_empty), .isFull(s_full), .isAlmostEmpty(s_ae),
    .isAlmostFull(s_af), .count(s_count)
`ifdef FIFO_ERR_FLAGS_EN
    , .overflow(s_ovf), .underflow(s_unf)
`endif
  );

  always #5 sys_clock = ~sys_clock;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Drive one cycle of stimulus and push the behaviour expected after the next edge.
  task automatic applyStimulus(input bit rst, input bit pm, input bit we, input bit re,
                               input logic [7:0] d);
    exp_t e;
    bit   wq, rq, ra, wa;
    @(negedge sys_clock);
    reset = rst; pulse_mode = pm; write_en = we; read_en = re; di = d;
    if (rst) begin
      m_q.delete();
      m_dout = 8'h00; m_ovf = 1'b0; m_unf = 1'b0;
      m_we = 1'b0; m_re = 1'b0;
    end else begin
      wq = pm ? (we && !m_we) : we;
      rq = pm ? (re && !m_re) : re;
      ra = rq && (m_q.size() != 0);
      wa = wq && ((m_q.size() < 16) || ra);
      if (rq && !ra) m_unf = 1'b1;
      if (wq && !wa) m_ovf = 1'b1;
      if (ra) m_dout = m_q.pop_front();
      if (wa) m_q.push_back(d);
      m_we = we; m_re = re;
    end
    e.dout = m_dout; e.cnt = m_q.size(); e.ovf = m_ovf; e.unf = m_unf;
    exp_q.push_back(e);
  endtask

  task automatic smallCycle(input bit rst, input bit we, input bit re, input logic [7:0] d);
    @(negedge sys_clock);
    s_reset = rst; s_we = we; s_re = re; s_di = d;
  endtask

  // Monitor: after each rising edge, pop the pending expectation and compare.
  initial begin
    exp_t e;
    forever begin
      @(posedge sys_clock);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checkOutput("sb_dout", d_out, e.dout);
        checkOutput("sb_count", count, e.cnt);
        checkOutput("sb_empty", isEmpty, e.cnt == 0);
        checkOutput("sb_full", isFull, e.cnt == 16);
        checkOutput("sb_almost_empty", isAlmostEmpty, e.cnt <= 2);
        checkOutput("sb_almost_full", isAlmostFull, e.cnt >= 12);
`ifdef FIFO_ERR_FLAGS_EN
        checkOutput("sb_overflow", overflow, e.ovf);
        checkOutput("sb_underflow", underflow, e.unf);
`endif
      end
    end
  end

  initial begin
    logic [7:0] expv;
    // Reset held for three cycles in pulse mode.
    for (int i = 0; i < 3; i++) applyStimulus(1, 1, 0, 0, 8'h00);
    applyStimulus(0, 1, 0, 0, 8'h00);
    checkOutput("reset_count", count, 0);
    checkOutput("reset_dout", d_out, 8'h00);
    checkOutput("reset_almost_full", isAlmostFull, 0);

    // Pulse mode: a long write_en high time still counts as one write.
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 1, 0, 8'h01);
    applyStimulus(0, 1, 0, 0, 8'h00);
    applyStimulus(0, 1, 1, 0, 8'h02);
    applyStimulus(0, 1, 0, 0, 8'h00);
    applyStimulus(0, 1, 1, 0, 8'h00);
    applyStimulus(0, 1, 0, 0, 8'h00);
    applyStimulus(0, 1, 1, 0, 8'h03);
    applyStimulus(0, 1, 0, 0, 8'h00);
    checkOutput("pulse_count", count, 4);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 1, 0, 1, 8'h00);
      applyStimulus(0, 1, 0, 0, 8'h00);
    end
    checkOutput("pulse_last_dout", d_out, 8'h03);
    checkOutput("pulse_drained", count, 0);

    // Level mode: fill to 16, one dropped write, then drain.
    for (int i = 0; i < 16; i++) applyStimulus(0, 0, 1, 0, 8'(i));
    applyStimulus(0, 0, 1, 0, 8'hEE);
    applyStimulus(0, 0, 0, 0, 8'h00);
    checkOutput("fill_count", count, 16);
    checkOutput("fill_full", isFull, 1);
    for (int i = 0; i < 16; i++) applyStimulus(0, 0, 0, 1, 8'h00);
    applyStimulus(0, 0, 0, 0, 8'h00);
    checkOutput("drain_dout", d_out, 8'h0F);
    checkOutput("drain_count", count, 0);

    // Full FIFO with simultaneous read and write, then empty with both.
    for (int i = 0; i < 16; i++) applyStimulus(0, 0, 1, 0, 8'h20 + 8'(i));
    applyStimulus(0, 0, 1, 1, 8'hAA);
    applyStimulus(0, 0, 0, 0, 8'h00);
    checkOutput("full_rw_dout", d_out, 8'h20);
    checkOutput("full_rw_count", count, 16);
    for (int i = 0; i < 16; i++) applyStimulus(0, 0, 0, 1, 8'h00);
    applyStimulus(0, 0, 0, 0, 8'h00);
    checkOutput("full_rw_last", d_out, 8'hAA);
    applyStimulus(0, 0, 1, 1, 8'h55);
    applyStimulus(0, 0, 0, 0, 8'h00);
    checkOutput("empty_rw_count", count, 1);
    checkOutput("empty_rw_dout", d_out, 8'hAA);
    applyStimulus(0, 0, 0, 1, 8'h00);
    applyStimulus(0, 0, 0, 0, 8'h00);
    checkOutput("empty_rw_readback", d_out, 8'h55);

    // Reset in the middle of a burst discards stored words.
    for (int i = 0; i < 7; i++) applyStimulus(0, 0, 1, 0, 8'h60 + 8'(i));
    applyStimulus(1, 0, 0, 0, 8'h00);
    applyStimulus(0, 0, 0, 0, 8'h00);
    checkOutput("midreset_count", count, 0);
    checkOutput("midreset_empty", isEmpty, 1);
    applyStimulus(0, 0, 1, 0, 8'h3C);
    applyStimulus(0, 0, 0, 1, 8'h00);
    applyStimulus(0, 0, 0, 0, 8'h00);
    checkOutput("midreset_data", d_out, 8'h3C);

    // DEPTH=5 instance: repeated 3-in/3-out rounds force pointer wrap.
    smallCycle(1, 0, 0, 8'h00);
    smallCycle(0, 0, 0, 8'h00);
    checkOutput("small_reset_empty", s_empty, 1);
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 3; k++) smallCycle(0, 1, 0, 8'h40 + 8'(r * 3 + k));
      smallCycle(0, 0, 0, 8'h00);
      checkOutput("small_count_3", s_count, 3);
      for (int k = 0; k < 3; k++) begin
        smallCycle(0, 0, 1, 8'h00);
        smallCycle(0, 0, 0, 8'h00);
        expv = 8'h40 + 8'(r * 3 + k);
        checkOutput("small_order", s_dout, expv);
      end
    end
    checkOutput("small_final_count", s_count, 0);

    @(posedge sys_clock);
    #2;
    checkOutput("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
